if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage. Holds the PC, fetches one instruction word per access over the shared bus, and drives the IF/ID pipeline register (if_pc, if_insn, if_en_) consumed by the decode stage.
- Honours pipeline stall/flush and decode-stage branch redirects.
- A one-entry skid buffer keeps a completed fetch when the pipeline is stalled.

Parameters:
RESET_VECTOR, 30'h0, word address loaded into the PC and if_pc on reset.
NOP_INSN, 32'h0, instruction word driven on if_insn when the stage is bubbled.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
stall  in  1  pipeline stall; holds the IF/ID register.
flush  in  1  pipeline flush; redirects the PC to new_pc.
new_pc  in  30  flush target (word address).
br_taken  in  1  branch taken from decode.
br_addr  in  30  branch target (word address).
busy  out  1  high while no fetched word is available for the next IF/ID update; pipeline controller stalls on it.
bus_req_  out  1  bus request, active low.
bus_grnt_  in  1  bus grant, active low.
bus_addr  out  30  fetch word address.
bus_as_  out  1  address strobe, active low.
bus_rw  out  1  constant 1 (read).
bus_wr_data  out  32  constant 0.
bus_rd_data  in  32  fetched word.
bus_rdy_  in  1  read data valid, active low.
if_pc  out  30  PC of the instruction in the IF/ID register.
if_insn  out  32  instruction in the IF/ID register.
if_en_  out  1  IF/ID valid, active low.

Behaviour:
Reset (asynchronous, high):
- pc = RESET_VECTOR; FSM = IDLE; skid buffer empty.
- if_pc = RESET_VECTOR; if_insn = NOP_INSN; if_en_ = 1.
- bus_req_ = 1; bus_as_ = 1; bus_addr = 0; busy = 1.

FSM (states IDLE, REQ, ACCESS, HOLD):
- IDLE: bus_req_ = 1. Next state is REQ unless flush is high.
- REQ: bus_req_ = 0. On bus_grnt_ == 0, next state is ACCESS.
- ACCESS: bus_req_ = 0; bus_as_ = 0; bus_addr = pc.
  - On bus_rdy_ == 0 the fetch completes.
  - If the word is consumed this cycle (stall == 0), stay in ACCESS for a back-to-back fetch of the next pc while grant is still held; otherwise go to REQ.
  - If stall == 1, capture bus_rd_data into the skid buffer and go to HOLD.
- HOLD: bus_req_ = 1; bus_as_ = 1. Stay while stall == 1. On stall == 0 the buffer is consumed, the buffer empties, and the next state is REQ.

busy:
- busy = 0 only when a completion (bus_rdy_ == 0 in ACCESS) or a full buffer exists this cycle; busy = 1 otherwise.

IF/ID update priority (each clock): flush > stall > br_taken > normal.
- flush:
  - pc <= new_pc; if_en_ <= 1; if_insn <= NOP_INSN; if_pc <= new_pc.
  - Any in-flight access is abandoned: FSM <= IDLE, bus_req_ and bus_as_ deasserted next cycle, buffer emptied.
  - Rising-edge bus_rdy_ data in the same cycle is discarded.
- stall (no flush):
  - if_pc, if_insn, if_en_ and pc are held.
  - A fetch completion goes to the buffer.
  - br_taken is ignored; decode re-presents it after the stall.
- br_taken (no flush, no stall):
  - The word delivered this cycle is the fall-through and is discarded: if_en_ <= 1, if_insn <= NOP_INSN, if_pc <= pc.
  - pc <= br_addr; a completed access counts as consumed.
  - If no word was available, the in-flight access continues but its data is dropped, then refetch from br_addr.
  - There is no delay slot.
- normal, word available (completion or buffer):
  - if_pc <= pc; if_insn <= word; if_en_ <= 0; pc <= pc + 1.
  - The buffer has priority over a new completion; both cannot occur together, because the FSM issues no access in HOLD.
- normal, no word:
  - if_en_ <= 1; if_insn <= NOP_INSN; pc held.

Arithmetic and buffer:
- pc + 1 is 30-bit modulo: 30'h3FFFFFFF wraps to 0.
- Skid buffer holds one entry (32-bit data plus full flag). It is never written while full.

Test Plan:
- Reset, then grant and rdy tied low → 3 cycles after reset release, if_en_ = 0, if_pc = RESET_VECTOR, if_insn = bus word; following words arrive at pc+1 every cycle, with bus_as_ held low.
- bus_rdy_ held high for 4 cycles in ACCESS → busy = 1, if_en_ = 1, and pc frozen for 4 cycles; the word is delivered the cycle after rdy_ falls.
- stall raised on the completion cycle with word 32'hDEADBEEF → IF/ID held, FSM in HOLD, bus_req_ = 1; after stall drops, if_insn = 32'hDEADBEEF next edge, with no re-fetch.
- br_taken with br_addr = 30'h100 while a word at pc = 30'h21 completes → next if_en_ = 1; next fetch address = 30'h100; then if_pc = 30'h100.
- flush with new_pc = 30'h40 mid-ACCESS (rdy_ low the same cycle) → word dropped, if_en_ = 1, FSM IDLE; next fetch address = 30'h40; flush and stall together: flush wins.
- pc = 30'h3FFFFFFF delivered → next fetch address = 30'h0; asynchronous reset asserted mid-ACCESS → all outputs reach reset values with no clock edge.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, bus fetch FSM, one-entry skid buffer and the
// IF/ID pipeline register feeding decode.
module if_stage #(
  parameter logic [29:0] RESET_VECTOR = 30'h0,
  parameter logic [31:0] NOP_INSN     = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [29:0] new_pc,
  input  logic        br_taken,
  input  logic [29:0] br_addr,
  output logic        busy,
  output logic        bus_req_,
  input  logic        bus_grnt_,
  output logic [29:0] bus_addr,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy_,
  output logic [29:0] if_pc,
  output logic [31:0] if_insn,
  output logic        if_en_
);

  typedef enum logic [1:0] {IDLE, REQ, ACCESS, HOLD} state_t;

  state_t      state;
  state_t      state_next;
  logic [29:0] pc;
  logic [31:0] buf_data;
  logic        buf_full;
  logic        drop;
  logic        completion;
  logic        fetched;
  logic        word_avail;
  logic [31:0] word;

  // drop marks an access that was in flight when a branch redirected the PC;
  // its data is the fall-through and must never reach IF/ID.
  assign completion  = (state == ACCESS) && !bus_rdy_;
  assign fetched     = completion && !drop;
  assign word_avail  = buf_full || fetched;
  assign word        = buf_full ? buf_data : bus_rd_data;
  assign busy        = !(completion || buf_full);
  assign bus_rw      = 1'b1;
  assign bus_wr_data = 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    bus_req_   = 1'b1;
    bus_as_    = 1'b1;
    bus_addr   = 30'h0;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        bus_req_ = 1'b0;
        if (!bus_grnt_) state_next = ACCESS;
      end
      ACCESS: begin
        bus_req_ = 1'b0;
        bus_as_  = 1'b0;
        bus_addr = pc;
        // Keep streaming while the grant is held; a stalled word parks in HOLD.
        if (completion) begin
          if (stall && !drop) state_next = HOLD;
          else if (bus_grnt_) state_next = REQ;
        end
      end
      HOLD: if (!stall) state_next = REQ;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_VECTOR;
      if_pc    <= RESET_VECTOR;
      if_insn  <= NOP_INSN;
      if_en_   <= 1'b1;
      buf_data <= 32'h0;
      buf_full <= 1'b0;
      drop     <= 1'b0;
    end else if (flush) begin
      pc       <= new_pc;
      if_pc    <= new_pc;
      if_insn  <= NOP_INSN;
      if_en_   <= 1'b1;
      buf_full <= 1'b0;
      drop     <= 1'b0;
    end else if (stall) begin
      if (fetched && !buf_full) begin
        buf_data <= bus_rd_data;
        buf_full <= 1'b1;
      end
      if (completion) drop <= 1'b0;
    end else if (br_taken) begin
      pc       <= br_addr;
      if_pc    <= pc;
      if_insn  <= NOP_INSN;
      if_en_   <= 1'b1;
      buf_full <= 1'b0;
      drop     <= (state == ACCESS) && bus_rdy_;
    end else begin
      if (word_avail) begin
        if_pc    <= pc;
        if_insn  <= word;
        if_en_   <= 1'b0;
        pc       <= pc + 30'd1;
        buf_full <= 1'b0;
      end else begin
        if_insn  <= NOP_INSN;
        if_en_   <= 1'b1;
      end
      if (completion) drop <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage; the bus returns {2'b11, address} as data
// unless a specific word is forced.
module tb_if_stage;

  localparam logic [29:0] RV  = 30'h20;
  localparam logic [31:0] NOP = 32'h13;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [29:0] new_pc;
  logic        br_taken;
  logic [29:0] br_addr;
  logic        busy;
  logic        bus_req_;
  logic        bus_grnt_;
  logic [29:0] bus_addr;
  logic        bus_as_;
  logic        bus_rw;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_rdy_;
  logic [29:0] if_pc;
  logic [31:0] if_insn;
  logic        if_en_;
  logic        use_override;
  logic [31:0] override_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign bus_rd_data = use_override ? override_data : {2'b11, bus_addr};

  if_stage #(.RESET_VECTOR(RV), .NOP_INSN(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .new_pc(new_pc),
    .br_taken(br_taken), .br_addr(br_addr), .busy(busy), .bus_req_(bus_req_),
    .bus_grnt_(bus_grnt_), .bus_addr(bus_addr), .bus_as_(bus_as_), .bus_rw(bus_rw),
    .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_),
    .if_pc(if_pc), .if_insn(if_insn), .if_en_(if_en_)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; new_pc = 30'h0;
    br_taken = 1'b0; br_addr = 30'h0; bus_grnt_ = 1'b0; bus_rdy_ = 1'b0;
    use_override = 1'b0; override_data = 32'h0;
    step();
    step();
    checks++; if (if_pc !== RV) begin errors++; $display("[TB] FAIL reset_if_pc got %h expected %h", if_pc, RV); end
    checks++; if (if_insn !== NOP) begin errors++; $display("[TB] FAIL reset_if_insn got %h expected %h", if_insn, NOP); end
    checks++; if (if_en_ !== 1'b1) begin errors++; $display("[TB] FAIL reset_if_en_ got %b expected 1", if_en_); end
    checks++; if ({bus_req_, bus_as_, busy} !== 3'b111) begin errors++; $display("[TB] FAIL reset_req_as_busy got %b expected 111", {bus_req_, bus_as_, busy}); end
    checks++; if (bus_addr !== 30'h0) begin errors++; $display("[TB] FAIL reset_bus_addr got %h expected 0", bus_addr); end
    checks++; if ({bus_rw, bus_wr_data} !== {1'b1, 32'h0}) begin errors++; $display("[TB] FAIL bus_rw_wr_data got %b/%h expected 1/0", bus_rw, bus_wr_data); end
  endtask

  task automatic test_stream();
    reset = 1'b0;
    step();
    checks++; if ({bus_req_, bus_as_} !== 2'b01) begin errors++; $display("[TB] FAIL req_state got %b expected 01", {bus_req_, bus_as_}); end
    step();
    checks++; if ({bus_as_, bus_addr} !== {1'b0, RV}) begin errors++; $display("[TB] FAIL first_access got %b/%h expected 0/%h", bus_as_, bus_addr, RV); end
    checks++; if ({busy, if_en_} !== 2'b01) begin errors++; $display("[TB] FAIL first_access_busy_en got %b expected 01", {busy, if_en_}); end
    step();
    checks++; if ({if_en_, if_pc, if_insn} !== {1'b0, RV, 32'hC000_0020}) begin errors++; $display("[TB] FAIL first_word got %b/%h/%h expected 0/%h/c0000020", if_en_, if_pc, if_insn, RV); end
    checks++; if ({bus_as_, bus_addr} !== {1'b0, 30'h21}) begin errors++; $display("[TB] FAIL back_to_back_addr got %b/%h expected 0/21", bus_as_, bus_addr); end
  endtask

  task automatic test_branch();
    br_taken = 1'b1; br_addr = 30'h100;
    step();
    br_taken = 1'b0;
    checks++; if ({if_en_, if_insn} !== {1'b1, NOP}) begin errors++; $display("[TB] FAIL branch_bubble got %b/%h expected 1/%h", if_en_, if_insn, NOP); end
    checks++; if (bus_addr !== 30'h100) begin errors++; $display("[TB] FAIL branch_fetch_addr got %h expected 100", bus_addr); end
    step();
    checks++; if ({if_en_, if_pc, if_insn} !== {1'b0, 30'h100, 32'hC000_0100}) begin errors++; $display("[TB] FAIL branch_target got %b/%h/%h expected 0/100/c0000100", if_en_, if_pc, if_insn); end
  endtask

  task automatic test_rdy_wait();
    bus_rdy_ = 1'b1;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL wait_busy got %b expected 1", busy); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if ({busy, if_en_, bus_addr} !== {2'b11, 30'h101}) begin errors++; $display("[TB] FAIL wait_cycle%0d got %b/%b/%h expected 1/1/101", i, busy, if_en_, bus_addr); end
    end
    bus_rdy_ = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL wait_done_busy got %b expected 0", busy); end
    step();
    checks++; if ({if_en_, if_pc, if_insn} !== {1'b0, 30'h101, 32'hC000_0101}) begin errors++; $display("[TB] FAIL wait_word got %b/%h/%h expected 0/101/c0000101", if_en_, if_pc, if_insn); end
  endtask

  task automatic test_stall();
    use_override = 1'b1; override_data = 32'hDEAD_BEEF; stall = 1'b1;
    step();
    checks++; if ({bus_req_, bus_as_, busy} !== 3'b110) begin errors++; $display("[TB] FAIL hold_bus got %b expected 110", {bus_req_, bus_as_, busy}); end
    step();
    checks++; if ({if_en_, if_pc, if_insn} !== {1'b0, 30'h101, 32'hC000_0101}) begin errors++; $display("[TB] FAIL hold_ifid got %b/%h/%h expected 0/101/c0000101", if_en_, if_pc, if_insn); end
    stall = 1'b0; use_override = 1'b0;
    step();
    checks++; if ({if_en_, if_pc, if_insn} !== {1'b0, 30'h102, 32'hDEAD_BEEF}) begin errors++; $display("[TB] FAIL skid_word got %b/%h/%h expected 0/102/deadbeef", if_en_, if_pc, if_insn); end
    checks++; if ({bus_req_, bus_as_} !== 2'b01) begin errors++; $display("[TB] FAIL after_hold_req got %b expected 01", {bus_req_, bus_as_}); end
    step();
    checks++; if (bus_addr !== 30'h103) begin errors++; $display("[TB] FAIL no_refetch_addr got %h expected 103", bus_addr); end
    step();
    checks++; if (if_pc !== 30'h103) begin errors++; $display("[TB] FAIL after_hold_word got %h expected 103", if_pc); end
  endtask

  task automatic test_flush();
    flush = 1'b1; stall = 1'b1; new_pc = 30'h40;
    step();
    flush = 1'b0; stall = 1'b0;
    checks++; if ({if_en_, if_pc, if_insn} !== {1'b1, 30'h40, NOP}) begin errors++; $display("[TB] FAIL flush_ifid got %b/%h/%h expected 1/40/%h", if_en_, if_pc, if_insn, NOP); end
    checks++; if ({bus_req_, bus_as_, busy} !== 3'b111) begin errors++; $display("[TB] FAIL flush_idle got %b expected 111", {bus_req_, bus_as_, busy}); end
    step();
    step();
    checks++; if (bus_addr !== 30'h40) begin errors++; $display("[TB] FAIL flush_fetch_addr got %h expected 40", bus_addr); end
    step();
    checks++; if ({if_en_, if_pc, if_insn} !== {1'b0, 30'h40, 32'hC000_0040}) begin errors++; $display("[TB] FAIL flush_target got %b/%h/%h expected 0/40/c0000040", if_en_, if_pc, if_insn); end
  endtask

  task automatic test_wrap();
    flush = 1'b1; new_pc = 30'h3FFF_FFFF;
    step();
    flush = 1'b0;
    step();
    step();
    checks++; if (bus_addr !== 30'h3FFF_FFFF) begin errors++; $display("[TB] FAIL wrap_top_addr got %h expected 3fffffff", bus_addr); end
    step();
    checks++; if (if_pc !== 30'h3FFF_FFFF) begin errors++; $display("[TB] FAIL wrap_top_word got %h expected 3fffffff", if_pc); end
    checks++; if (bus_addr !== 30'h0) begin errors++; $display("[TB] FAIL wrap_next_addr got %h expected 0", bus_addr); end
    step();
    checks++; if ({if_pc, if_insn} !== {30'h0, 32'hC000_0000}) begin errors++; $display("[TB] FAIL wrap_zero_word got %h/%h expected 0/c0000000", if_pc, if_insn); end
  endtask

  task automatic test_async_reset();
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({if_en_, if_pc, if_insn} !== {1'b1, RV, NOP}) begin errors++; $display("[TB] FAIL async_ifid got %b/%h/%h expected 1/%h/%h", if_en_, if_pc, if_insn, RV, NOP); end
    checks++; if ({bus_req_, bus_as_, busy, bus_addr} !== {3'b111, 30'h0}) begin errors++; $display("[TB] FAIL async_bus got %b/%h expected 111/0", {bus_req_, bus_as_, busy}, bus_addr); end
    step();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_branch();
    test_rdy_wait();
    test_stall();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
